// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The requester side drives start/operands; the adder side returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// The result appears WIDTH cycles after an accepted start, with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, sum_reg;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg, cout_reg;
  logic             ha1_s, ha1_c, ha2_c, fa_s, fa_c;

  // Full adder built from two half adders; the carries are OR-ed.
  assign ha1_s    = a_reg[0] ^ b_reg[0];
  assign ha1_c    = a_reg[0] & b_reg[0];
  assign fa_s     = ha1_s ^ carry_reg;
  assign ha2_c    = ha1_s & carry_reg;
  assign fa_c     = ha1_c | ha2_c;
  assign res_next = {fa_s, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            res_reg   <= '0;
            cnt_reg   <= '0;
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_c;
          res_reg   <= res_next;
          cnt_reg   <= cnt_reg + 1'b1;
          // The last bit is folded in on the same edge the result is published.
          if (cnt_reg == LAST) begin
            sum_reg  <= res_next;
            cout_reg <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg == SHIFT);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the timing/protocol
// cases and a 4-bit instance swept over every operand/carry combination.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] last_sum  = 8'h00;
  logic       last_cout = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) m ();
  serial_adder_if #(.WIDTH(4)) n ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(m));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(n));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One 8-bit addition with a start pulse; optionally pulses a spurious start
  // with other operands at SHIFT cycle index inj (0-based).
  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input int inj, input string tag);
    m.a = a; m.b = b; m.cin = cin; m.start = 1'b1;
    tick();
    m.start = 1'b0;
    m.a = ~a; m.b = ~b; m.cin = ~cin;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, 64'(m.busy), 64'(1));
      chk({tag, "_nodone"}, 64'(m.done), 64'(0));
      chk({tag, "_sumhold"}, 64'({m.cout, m.sum}), 64'({last_cout, last_sum}));
      if (i == inj) begin
        m.start = 1'b1; m.a = 8'h01; m.b = 8'h01; m.cin = 1'b0;
      end else begin
        m.start = 1'b0;
      end
      tick();
    end
    m.start = 1'b0;
    chk({tag, "_done"}, 64'(m.done), 64'(1));
    chk({tag, "_busy_done"}, 64'(m.busy), 64'(0));
    chk({tag, "_sum"}, 64'(m.sum), 64'(es));
    chk({tag, "_cout"}, 64'(m.cout), 64'(ec));
    $display("[TB] %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", tag, a, b, cin, m.sum, m.cout);
    last_sum = es; last_cout = ec;
    tick();
    chk({tag, "_idle"}, 64'({m.busy, m.done}), 64'(0));
  endtask

  initial begin
    m.start = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0;
    n.start = 1'b0; n.a = '0; n.b = '0; n.cin = 1'b0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst8", 64'({m.busy, m.done, m.cout, m.sum}), 64'(0));
    chk("rst4", 64'({n.busy, n.done, n.cout, n.sum}), 64'(0));
    $display("[TB] reset busy=%0d done=%0d sum=%02h cout=%0d", m.busy, m.done, m.sum, m.cout);

    run_add(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, -1, "add_3c_0f");
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1, "add_ff_01");
    run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1, "add_ff_ff_c");
    run_add(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 2, "ignore_start");

    // Abort in the 4th SHIFT cycle; sum currently holds 0x8D.
    m.a = 8'hAA; m.b = 8'h55; m.cin = 1'b0; m.start = 1'b1;
    tick();
    m.start = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy_pre", 64'(m.busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", 64'({m.busy, m.done}), 64'(0));
    chk("abort_sum", 64'(m.sum), 64'(0));
    chk("abort_cout", 64'(m.cout), 64'(0));
    $display("[TB] abort a=aa b=55 -> busy=%0d done=%0d sum=%02h cout=%0d", m.busy, m.done, m.sum, m.cout);
    for (int i = 0; i < 10; i++) begin
      chk("abort_nodone", 64'({m.busy, m.done}), 64'(0));
      tick();
    end

    // Start held high: one result every 10 cycles.
    m.a = 8'h12; m.b = 8'h34; m.cin = 1'b0; m.start = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 7; i++) begin
        chk("held_nodone", 64'(m.done), 64'(0));
        tick();
      end
      tick();
      chk("held_done", 64'(m.done), 64'(1));
      chk("held_sum", 64'({m.cout, m.sum}), 64'(9'h046));
      $display("[TB] held rep=%0d a=12 b=34 -> sum=%02h cout=%0d", r, m.sum, m.cout);
      tick();
      chk("held_idle", 64'({m.busy, m.done}), 64'(0));
      tick();
      chk("held_reaccept", 64'(m.busy), 64'(1));
    end
    m.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("held_settle", 64'({m.busy, m.done}), 64'(0));

    // Exhaustive 4-bit sweep against a+b+cin.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] ref_v;
          ref_v = 5'(a) + 5'(b) + 5'(c);
          n.a = 4'(a); n.b = 4'(b); n.cin = 1'(c); n.start = 1'b1;
          tick();
          n.start = 1'b0;
          for (int i = 0; i < 4; i++) tick();
          chk("w4", 64'({n.done, n.cout, n.sum}), 64'({1'b1, ref_v}));
          $display("[TB] w4 a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d", a, b, c, n.sum, n.cout);
          tick();
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
